// File: rtl/stochastic_sequencer.sv
`timescale 1ns/1ps
// stochastic_sequencer
// Sequences the stochastic multiply / scaled-add datapath. Two operands are
// captured on start. Three LFSR-driven stochastic number generators then
// stream for a fixed 255-cycle window, and the ones of the output stream are
// counted into an 8-bit result.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; streams forced low, result held
// S_RUN  | 255-cycle stream window; LFSRs advance, ones accumulate
// S_DONE | one cycle; result already updated, done pulses, back to idle
module stochastic_sequencer #(
   parameter logic [7:0] SEED_A = 8'h01,
   parameter logic [7:0] SEED_B = 8'hA5,
   parameter logic [7:0] SEED_S = 8'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       stream_a,
   output logic       stream_b,
   output logic       stream_y
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Window length minus one: the down-counter reaches zero on the last
   // counted cycle of the window.
   localparam logic [7:0] WINDOW_LAST = 8'd254;
   localparam logic [7:0] SEL_THRESH  = 8'd127;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] lfsr_a;
   logic [7:0] lfsr_b;
   logic [7:0] lfsr_s;
   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic       op_reg;
   logic [7:0] ones_cnt;
   logic [7:0] cyc_left;

   logic       accept;
   logic       in_run;
   logic       run_last;
   logic       bit_a;
   logic       bit_b;
   logic       bit_sel;
   logic       bit_y;

   // Fibonacci step for x^8 + x^6 + x^5 + x^4 + 1 (maximal, never reaches 0
   // from a non-zero seed).
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign in_run   = (state == S_RUN);
   assign accept   = (state == S_IDLE) && start;
   assign run_last = in_run && !abort && (cyc_left == 8'd0);

   // Comparators of the stochastic number generators. A value v in 1..255
   // satisfies v <= x for exactly x of the 255 LFSR states.
   assign bit_a   = (lfsr_a <= a_reg);
   assign bit_b   = (lfsr_b <= b_reg);
   assign bit_sel = (lfsr_s <= SEL_THRESH);
   assign bit_y   = op_reg ? (bit_sel ? bit_b : bit_a) : (bit_a & bit_b);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; start only matters in idle, abort only in run.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (cyc_left == 8'd0) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode; streams are only exported while the window is open.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      stream_a = 1'b0;
      stream_b = 1'b0;
      stream_y = 1'b0;
      case (state)
         S_RUN: begin
            busy     = 1'b1;
            stream_a = bit_a;
            stream_b = bit_b;
            stream_y = bit_y;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Operand capture and LFSR reseed on accepted start; LFSRs advance every
   // run cycle (including an aborting one, harmless since start reseeds).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg  <= 8'd0;
         b_reg  <= 8'd0;
         op_reg <= 1'b0;
         lfsr_a <= SEED_A;
         lfsr_b <= SEED_B;
         lfsr_s <= SEED_S;
      end else if (accept) begin
         a_reg  <= a;
         b_reg  <= b;
         op_reg <= op;
         lfsr_a <= SEED_A;
         lfsr_b <= SEED_B;
         lfsr_s <= SEED_S;
      end else if (in_run) begin
         lfsr_a <= lfsr_step(lfsr_a);
         lfsr_b <= lfsr_step(lfsr_b);
         lfsr_s <= lfsr_step(lfsr_s);
      end
   end

   // Window timer (down-counter, terminal count at zero) and ones
   // accumulator. 255 cycles of at most one each cannot overflow 8 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_left <= WINDOW_LAST;
         ones_cnt <= 8'd0;
      end else if (accept) begin
         cyc_left <= WINDOW_LAST;
         ones_cnt <= 8'd0;
      end else if (in_run) begin
         if (cyc_left != 8'd0) begin
            cyc_left <= cyc_left - 8'd1;
         end
         ones_cnt <= ones_cnt + {7'd0, bit_y};
      end
   end

   // Result is loaded on the edge into DONE so it is valid alongside done;
   // the final window bit is folded in here. Abort never touches it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= 8'd0;
      end else if (run_last) begin
         result <= ones_cnt + {7'd0, bit_y};
      end
   end

endmodule

// File: tb/tb_stochastic_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for stochastic_sequencer: each accepted run pushes its
// expected result; a monitor pops and compares whenever done is seen.
module tb_stochastic_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       op;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       stream_a;
   logic       stream_b;
   logic       stream_y;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int exp_dones = 0;
   int last_exp = 0;
   int exp_q[$];

   stochastic_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .stream_a (stream_a),
      .stream_b (stream_b),
      .stream_y (stream_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model of one full window, from seeds 01/A5/5A.
   function automatic int ref_run(input logic o, input logic [7:0] va, input logic [7:0] vb);
      logic [7:0] la;
      logic [7:0] lb;
      logic [7:0] ls;
      logic       sa;
      logic       sb;
      logic       sl;
      int         cnt;
      la = 8'h01; lb = 8'hA5; ls = 8'h5A; cnt = 0;
      for (int i = 0; i < 255; i++) begin
         sa = (la <= va);
         sb = (lb <= vb);
         sl = (ls <= 8'd127);
         if (o ? (sl ? sb : sa) : (sa & sb)) cnt++;
         la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
         lb = {lb[6:0], lb[7] ^ lb[5] ^ lb[4] ^ lb[3]};
         ls = {ls[6:0], ls[7] ^ ls[5] ^ ls[4] ^ ls[3]};
      end
      return cnt;
   endfunction

   // Monitor: every done must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            chk("result", {24'd0, result}, exp_q.pop_front());
         end
      end
   end

   // One run: exp >= 0 is a hand value, exp < 0 uses the model.
   // hs pulses extra starts; abort_at > 0 aborts at that run edge.
   task automatic do_run(input logic o, input logic [7:0] va, input logic [7:0] vb,
                         input int exp, input bit hs, input int abort_at);
      int n;
      int bcnt;
      int acnt;
      int bon;
      bit seen;
      bit stop;
      int e;
      e = (exp >= 0) ? exp : ref_run(o, va, vb);
      n = 0; bcnt = 0; acnt = 0; bon = 0; seen = 0; stop = 0;
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      if (abort_at == 0) begin
         exp_q.push_back(e);
         exp_dones++;
      end
      while (!stop) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            a = ~va; b = ~vb; op = ~o;
         end
         if (busy === 1'b1) bcnt++;
         if (stream_a === 1'b1) acnt++;
         if (stream_b === 1'b1) bon++;
         if (done === 1'b1) seen = 1;
         if (abort_at > 0 && n == abort_at + 1) begin
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_streams", {29'd0, stream_a, stream_b, stream_y}, 32'd0);
            chk("abort_result_kept", {24'd0, result}, last_exp);
            stop = 1;
         end
         start = hs && (n == 10 || n == 254 || n == 256);
         abort = (abort_at > 0) && (n == abort_at);
         if (seen || n >= 400) stop = 1;
      end
      if (start) begin
         @(negedge clk);
         start = 1'b0;
      end
      if (abort_at == 0) begin
         chk("done_seen", {31'd0, seen}, 32'd1);
         chk("done_latency", n, 32'd256);
         chk("busy_cycles", bcnt, 32'd255);
         chk("stream_a_ones", acnt, {24'd0, va});
         chk("stream_b_ones", bon, {24'd0, vb});
         last_exp = e;
      end
   endtask

   initial begin
      int idle_busy;
      rst = 1'b1; start = 1'b0; abort = 1'b0; op = 1'b0; a = 8'd0; b = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_streams", {29'd0, stream_a, stream_b, stream_y}, 32'd0);
      rst = 1'b0;

      do_run(1'b0, 8'd255, 8'd77, 77, 0, 0);

      // Reset in the middle of a run.
      @(negedge clk);
      op = 1'b0; a = 8'd200; b = 8'd50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrun_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_result", {24'd0, result}, 32'd0);
      chk("midrst_streams", {29'd0, stream_a, stream_b, stream_y}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_exp = 0;

      do_run(1'b0, 8'd255, 8'd255, 255, 0, 0);
      do_run(1'b0, 8'd0,   8'd200, 0,   0, 0);
      do_run(1'b1, 8'd130, 8'd130, -1,  0, 0);
      do_run(1'b1, 8'd0,   8'd0,   0,   0, 0);
      do_run(1'b0, 8'd128, 8'd128, -1,  0, 0);
      chk("approx_in_range", {31'd0, (result >= 8'd48 && result <= 8'd80)}, 32'd1);
      do_run(1'b1, 8'd255, 8'd0,   128, 0, 0);

      // Extra starts during run and in DONE must be ignored.
      do_run(1'b0, 8'd200, 8'd100, -1, 1, 0);
      idle_busy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy === 1'b1) idle_busy++;
      end
      chk("no_requeued_run", idle_busy, 32'd0);

      // Abort keeps the previous result; a fresh start then completes.
      do_run(1'b0, 8'd255, 8'd77, 77, 0, 0);
      do_run(1'b0, 8'd255, 8'd255, 0, 0, 100);
      do_run(1'b0, 8'd255, 8'd255, 255, 0, 0);

      repeat (5) @(negedge clk);
      chk("done_count", done_cnt, exp_dones);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
